// File: rtl/blob_pkg.sv
// Shared types and defaults for the blob bounding-box detector.
// Optional centroid output is enabled with BLOB_CENTROID_EN.
package blob_pkg;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

  localparam int H_ACTIVE_DEF   = 640;
  localparam int V_ACTIVE_DEF   = 480;
  localparam int PIX_W_DEF      = 8;
  localparam int MIN_PIXELS_DEF = 16;

  // Counter width able to hold every pixel of a frame.
  function automatic int cnt_width(input int h, input int v);
    return $clog2(h * v + 1);
  endfunction

endpackage

// File: rtl/blob_seq_divider.sv
// Restoring divider, one quotient bit per cycle, ITER cycles from i_start to o_done.
// Assumes the quotient fits in ITER bits; only the low Q_W bits are kept.
module blob_seq_divider #(
  parameter int NUM_W = 9,
  parameter int DEN_W = 6,
  parameter int ITER  = 6,
  parameter int Q_W   = 3
)(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [NUM_W-1:0] i_num,
  input  logic [DEN_W-1:0] i_den,
  output logic             o_done,
  output logic [Q_W-1:0]   o_quot
);

  localparam int IT_W = $clog2(ITER + 1);

  logic [DEN_W-1:0] rem_q, rem_src;
  logic [ITER-1:0]  lo_q, lo_src;
  logic [Q_W-1:0]   quot_q, quot_src;
  logic [IT_W-1:0]  it_q;
  logic             busy_q;
  logic [DEN_W:0]   trial, diff;
  logic             ge;

  // The load cycle already performs the first step.
  always_comb begin
    rem_src  = i_start ? DEN_W'(i_num >> ITER) : rem_q;
    lo_src   = i_start ? i_num[ITER-1:0] : lo_q;
    quot_src = i_start ? '0 : quot_q;
    trial    = {rem_src, lo_src[ITER-1]};
    diff     = trial - {1'b0, i_den};
    ge       = ~diff[DEN_W];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rem_q  <= '0;
      lo_q   <= '0;
      quot_q <= '0;
      it_q   <= '0;
      busy_q <= 1'b0;
      o_done <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (i_start || busy_q) begin
        rem_q  <= ge ? diff[DEN_W-1:0] : trial[DEN_W-1:0];
        lo_q   <= lo_src << 1;
        quot_q <= (quot_src << 1) | Q_W'(ge);
      end
      if (i_start) begin
        it_q   <= IT_W'(ITER - 1);
        busy_q <= (ITER > 1);
        o_done <= (ITER == 1);
      end else if (busy_q) begin
        it_q <= it_q - 1'b1;
        if (it_q == IT_W'(1)) begin
          busy_q <= 1'b0;
          o_done <= 1'b1;
        end
      end
    end
  end

  assign o_quot = quot_q;

endmodule

// File: rtl/blob_bbox_detect.sv
// Per-frame bright-pixel bounding box and count over a raster grayscale stream.
// Define BLOB_CENTROID_EN to add the centroid outputs via blob_seq_divider.
module blob_bbox_detect
  import blob_pkg::*;
#(
  parameter  int H_ACTIVE   = H_ACTIVE_DEF,
  parameter  int V_ACTIVE   = V_ACTIVE_DEF,
  parameter  int PIX_W      = PIX_W_DEF,
  parameter  int MIN_PIXELS = MIN_PIXELS_DEF,
  localparam int X_W        = $clog2(H_ACTIVE),
  localparam int Y_W        = $clog2(V_ACTIVE),
  localparam int CNT_W      = cnt_width(H_ACTIVE, V_ACTIVE)
)(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_pix_valid,
  input  logic [PIX_W-1:0] i_pix_gray,
  input  logic [PIX_W-1:0] i_thresh,
  output logic             o_busy,
  output logic             o_blob_end,
  output logic             o_blob_found,
  output logic [X_W-1:0]   o_x_min,
  output logic [X_W-1:0]   o_x_max,
  output logic [Y_W-1:0]   o_y_min,
  output logic [Y_W-1:0]   o_y_max,
  output logic [CNT_W-1:0] o_pix_count,
  output logic [X_W-1:0]   o_cx,
  output logic [Y_W-1:0]   o_cy
);

  state_t           state_q, state_d;
  logic             start_d;
  logic [PIX_W-1:0] thr_q;
  logic [X_W-1:0]   x_q, xmin_q, xmax_q;
  logic [Y_W-1:0]   y_q, ymin_q, ymax_q;
  logic [CNT_W-1:0] cnt_q;
  logic             rise, arm, eol, last_px, px_take, bright, finish, found;

  always_comb begin
    rise    = i_start & ~start_d;
    arm     = (state_q == S_IDLE) && rise;
    eol     = (x_q == X_W'(H_ACTIVE - 1));
    last_px = i_pix_valid && eol && (y_q == Y_W'(V_ACTIVE - 1));
    // The final pixel still counts when i_start drops on that same cycle.
    px_take = (state_q == S_SCAN) && i_pix_valid && (i_start || last_px);
    bright  = (i_pix_gray >= thr_q);
    found   = (cnt_q >= CNT_W'(MIN_PIXELS));
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (rise) state_d = S_SCAN;
      S_SCAN: begin
        if (last_px)       state_d = S_DONE;
        else if (!i_start) state_d = S_IDLE;
      end
      S_DONE: if (finish) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      start_d <= 1'b0;
    end else begin
      state_q <= state_d;
      start_d <= i_start;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      thr_q        <= '0;
      x_q          <= '0;
      y_q          <= '0;
      xmin_q       <= '0;
      xmax_q       <= '0;
      ymin_q       <= '0;
      ymax_q       <= '0;
      cnt_q        <= '0;
      o_blob_end   <= 1'b0;
      o_blob_found <= 1'b0;
      o_x_min      <= '0;
      o_x_max      <= '0;
      o_y_min      <= '0;
      o_y_max      <= '0;
      o_pix_count  <= '0;
    end else begin
      o_blob_end <= 1'b0;
      if (arm) begin
        thr_q        <= i_thresh;
        x_q          <= '0;
        y_q          <= '0;
        xmin_q       <= '1;
        ymin_q       <= '1;
        xmax_q       <= '0;
        ymax_q       <= '0;
        cnt_q        <= '0;
        o_blob_found <= 1'b0;
        o_x_min      <= '0;
        o_x_max      <= '0;
        o_y_min      <= '0;
        o_y_max      <= '0;
        o_pix_count  <= '0;
      end
      if (px_take) begin
        if (bright) begin
          if (x_q < xmin_q) xmin_q <= x_q;
          if (x_q > xmax_q) xmax_q <= x_q;
          if (y_q < ymin_q) ymin_q <= y_q;
          if (y_q > ymax_q) ymax_q <= y_q;
          if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
        end
        if (eol) begin
          x_q <= '0;
          y_q <= y_q + 1'b1;
        end else begin
          x_q <= x_q + 1'b1;
        end
      end
      if (state_q == S_DONE && finish) begin
        o_blob_end   <= 1'b1;
        o_blob_found <= found;
        o_x_min      <= found ? xmin_q : '0;
        o_x_max      <= found ? xmax_q : '0;
        o_y_min      <= found ? ymin_q : '0;
        o_y_max      <= found ? ymax_q : '0;
        o_pix_count  <= cnt_q;
      end
    end
  end

  assign o_busy = (state_q != S_IDLE);

`ifdef BLOB_CENTROID_EN
  localparam int SX_W = X_W + CNT_W;
  localparam int SY_W = Y_W + CNT_W;

  logic [SX_W-1:0] sum_x_q;
  logic [SY_W-1:0] sum_y_q;
  logic            div_run_q, div_start, dx_done, dy_done;
  logic [X_W-1:0]  dx_quot;
  logic [Y_W-1:0]  dy_quot;

  assign div_start = (state_q == S_DONE) && (cnt_q != '0) && !div_run_q;
  assign finish    = (cnt_q == '0) || (div_run_q && dx_done && dy_done);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sum_x_q   <= '0;
      sum_y_q   <= '0;
      div_run_q <= 1'b0;
      o_cx      <= '0;
      o_cy      <= '0;
    end else begin
      if (arm) begin
        sum_x_q <= '0;
        sum_y_q <= '0;
        o_cx    <= '0;
        o_cy    <= '0;
      end
      if (px_take && bright) begin
        sum_x_q <= sum_x_q + SX_W'(x_q);
        sum_y_q <= sum_y_q + SY_W'(y_q);
      end
      if (div_start) div_run_q <= 1'b1;
      if (state_q == S_DONE && finish) begin
        div_run_q <= 1'b0;
        o_cx      <= (cnt_q == '0) ? '0 : dx_quot;
        o_cy      <= (cnt_q == '0) ? '0 : dy_quot;
      end
    end
  end

  // x and y run in parallel so both quotients land on the same cycle.
  blob_seq_divider #(.NUM_W(SX_W), .DEN_W(CNT_W), .ITER(CNT_W), .Q_W(X_W)) u_div_x (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(div_start),
    .i_num(sum_x_q), .i_den(cnt_q), .o_done(dx_done), .o_quot(dx_quot)
  );

  blob_seq_divider #(.NUM_W(SY_W), .DEN_W(CNT_W), .ITER(CNT_W), .Q_W(Y_W)) u_div_y (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(div_start),
    .i_num(sum_y_q), .i_den(cnt_q), .o_done(dy_done), .o_quot(dy_quot)
  );
`else
  assign finish = 1'b1;
  assign o_cx   = '0;
  assign o_cy   = '0;
`endif

endmodule

// File: tb/tb_blob_bbox_detect.sv
// Self-checking bench for blob_bbox_detect: table vectors, hand sequences, random frames vs model.
module tb_blob_bbox_detect;

  localparam int H     = 8;
  localparam int V     = 6;
  localparam int PW    = 8;
  localparam int MINP  = 2;
  localparam int NPIX  = H * V;
  localparam int X_W   = $clog2(H);
  localparam int Y_W   = $clog2(V);
  localparam int CNT_W = $clog2(H * V + 1);
`ifdef BLOB_CENTROID_EN
  localparam bit CENT = 1'b1;
`else
  localparam bit CENT = 1'b0;
`endif

  logic             i_clk = 1'b0;
  logic             i_rst_n;
  logic             i_start, i_pix_valid;
  logic [PW-1:0]    i_pix_gray, i_thresh;
  logic             o_busy, o_blob_end, o_blob_found;
  logic [X_W-1:0]   o_x_min, o_x_max, o_cx;
  logic [Y_W-1:0]   o_y_min, o_y_max, o_cy;
  logic [CNT_W-1:0] o_pix_count;

  blob_bbox_detect #(.H_ACTIVE(H), .V_ACTIVE(V), .PIX_W(PW), .MIN_PIXELS(MINP)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_pix_valid(i_pix_valid),
    .i_pix_gray(i_pix_gray), .i_thresh(i_thresh), .o_busy(o_busy), .o_blob_end(o_blob_end),
    .o_blob_found(o_blob_found), .o_x_min(o_x_min), .o_x_max(o_x_max), .o_y_min(o_y_min),
    .o_y_max(o_y_max), .o_pix_count(o_pix_count), .o_cx(o_cx), .o_cy(o_cy)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [NPIX-1:0] mask;
    bit gaps, fall;
    int cnt, found, x0, x1, y0, y1, cx, cy;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  function automatic int cexp(input int v);
    return CENT ? v : 0;
  endfunction

  function automatic logic [NPIX-1:0] px(input int x, input int y);
    logic [NPIX-1:0] m;
    m = '0;
    m[y * H + x] = 1'b1;
    return m;
  endfunction

  // Reference: scan the mask as a picture and apply the frame rules directly.
  function automatic vec_t model(input logic [NPIX-1:0] mask);
    vec_t e;
    int sx, sy, x0, x1, y0, y1;
    sx = 0; sy = 0; x0 = H; x1 = -1; y0 = V; y1 = -1;
    e.mask = mask; e.gaps = 0; e.fall = 0; e.cnt = 0;
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++)
        if (mask[y * H + x]) begin
          e.cnt++; sx += x; sy += y;
          if (x < x0) x0 = x;
          if (x > x1) x1 = x;
          if (y < y0) y0 = y;
          if (y > y1) y1 = y;
        end
    e.found = (e.cnt >= MINP) ? 1 : 0;
    e.x0 = e.found ? x0 : 0; e.x1 = e.found ? x1 : 0;
    e.y0 = e.found ? y0 : 0; e.y1 = e.found ? y1 : 0;
    e.cx = cexp(e.cnt ? sx / e.cnt : 0);
    e.cy = cexp(e.cnt ? sy / e.cnt : 0);
    return e;
  endfunction

  task automatic drive_pix(input bit b);
    i_pix_valid = 1'b1;
    i_pix_gray  = b ? PW'($urandom_range(128, 255)) : PW'($urandom_range(0, 127));
  endtask

  task automatic run_frame(input string tag, input vec_t v);
    int lat, early;
    i_start = 1'b1;
    step();
    chk({tag, "_busy"}, int'(o_busy), 1);
    for (int p = 0; p < NPIX; p++) begin
      if (v.gaps) begin
        repeat ($urandom_range(0, 2)) begin
          i_pix_valid = 1'b0;
          i_pix_gray  = PW'($urandom);
          step();
        end
      end
      drive_pix(v.mask[p]);
      if (v.fall && p == NPIX - 1) i_start = 1'b0;
      step();
    end
    i_pix_valid = 1'b0;
    early = int'(o_blob_end);
    lat = (CENT && v.cnt != 0) ? 2 + CNT_W : 2;
    repeat (lat - 2) begin
      step();
      early += int'(o_blob_end);
    end
    chk({tag, "_end_early"}, early, 0);
    step();
    chk({tag, "_end"}, int'(o_blob_end), 1);
    chk({tag, "_found"}, int'(o_blob_found), v.found);
    chk({tag, "_xmin"}, int'(o_x_min), v.x0);
    chk({tag, "_xmax"}, int'(o_x_max), v.x1);
    chk({tag, "_ymin"}, int'(o_y_min), v.y0);
    chk({tag, "_ymax"}, int'(o_y_max), v.y1);
    chk({tag, "_count"}, int'(o_pix_count), v.cnt);
    chk({tag, "_cx"}, int'(o_cx), v.cx);
    chk({tag, "_cy"}, int'(o_cy), v.cy);
    i_start = 1'b0;
    step();
    chk({tag, "_end_pulse"}, int'(o_blob_end), 0);
    chk({tag, "_hold"}, int'(o_pix_count), v.cnt);
    chk({tag, "_idle"}, int'(o_busy), 0);
  endtask

  vec_t tbl[5];
  vec_t rv;

  initial begin
    int ends;
    logic [NPIX-1:0] m;
    tbl[0] = '{px(2,1) | px(5,1) | px(3,4), 0, 0, 3, 1, 2, 5, 1, 4, cexp(3), cexp(2)};
    tbl[1] = '{'0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[2] = '{px(7,5), 0, 0, 1, 0, 0, 0, 0, 0, cexp(7), cexp(5)};
    tbl[3] = '{px(0,0) | px(7,5), 1, 1, 2, 1, 0, 7, 0, 5, cexp(3), cexp(2)};
    tbl[4] = '{'1, 0, 0, 48, 1, 0, 7, 0, 5, cexp(3), cexp(2)};

    i_rst_n = 1'b0; i_start = 1'b0; i_pix_valid = 1'b0;
    i_pix_gray = '0; i_thresh = 8'd128;
    step(); step();
    i_rst_n = 1'b1;
    step();
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_end", int'(o_blob_end), 0);
    chk("rst_found", int'(o_blob_found), 0);
    chk("rst_box", int'({o_x_min, o_x_max, o_y_min, o_y_max}), 0);
    chk("rst_count", int'(o_pix_count), 0);

    for (int i = 0; i < 5; i++) run_frame($sformatf("vec%0d", i), tbl[i]);

    // Abort after 20 pixels: no completion, cleared outputs remain.
    i_start = 1'b1;
    step();
    for (int p = 0; p < 20; p++) begin drive_pix(1'b1); step(); end
    i_start = 1'b0;
    ends = 0;
    repeat (60) begin
      drive_pix($urandom_range(0, 1));
      step();
      ends += int'(o_blob_end);
    end
    i_pix_valid = 1'b0;
    chk("abort_no_end", ends, 0);
    chk("abort_busy", int'(o_busy), 0);
    chk("abort_count", int'(o_pix_count), 0);
    chk("abort_found", int'(o_blob_found), 0);
    run_frame("after_abort", model(px(0,0) | px(7,5)));

    // Start fall on the last pixel plus idle gaps.
    rv = model(px(1,0) | px(6,2) | px(4,5));
    rv.gaps = 1; rv.fall = 1;
    run_frame("fall_last", rv);

    // Reset mid-scan, then a clean frame.
    i_start = 1'b1;
    step();
    for (int p = 0; p < 10; p++) begin drive_pix(1'b1); step(); end
    i_rst_n = 1'b0;
    #1;
    chk("midrst_busy", int'(o_busy), 0);
    chk("midrst_count", int'(o_pix_count), 0);
    i_start = 1'b0; i_pix_valid = 1'b0;
    step();
    i_rst_n = 1'b1;
    step();
    rv = model(px(1,1) | px(3,3));
    chk("centroid_model_x", rv.cx, cexp(2));
    run_frame("after_rst", rv);

    for (int r = 0; r < 8; r++) begin
      for (int p = 0; p < NPIX; p++) m[p] = ($urandom_range(0, 7) == 0);
      rv = model(m);
      rv.gaps = $urandom_range(0, 1);
      rv.fall = $urandom_range(0, 1);
      run_frame($sformatf("rnd%0d", r), rv);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
